// File: rtl/fp_vr_pkg.sv
// Shared types and sizing helpers for the FP valid-ready responder shell.
// Default response field widths come from FP_VR_RES_W / FP_VR_TAG_W.
`ifndef FP_VR_RES_W
`define FP_VR_RES_W 16
`endif
`ifndef FP_VR_TAG_W
`define FP_VR_TAG_W 8
`endif

package fp_vr_pkg;

    localparam int FFLAGS_W = 5;

    typedef struct packed {
        logic [`FP_VR_TAG_W-1:0] tag;
        logic [`FP_VR_RES_W-1:0] res;
        logic [FFLAGS_W-1:0]     fflags;
    } resp_t;

    // Index width for a DEPTH-entry array; never zero so DEPTH=1 still has a pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fp_vr_fifo.sv
// Result buffer for the responder shell: DEPTH entries, pointers wrap modulo DEPTH
// so any DEPTH >= 1 works. Head is read straight from the storage registers.
module fp_vr_fifo
    import fp_vr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(resp_t),
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A simultaneous pop frees the slot being written, so push is legal even when full.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fp_vr_resp_shell.sv
// Valid-ready responder around a fixed-latency, non-stallable FP datapath, with credit-limited
// outstanding ops. Defining FP_VR_RESP_BYPASS_EN lets a result skip the buffer when it is empty.
module fp_vr_resp_shell
    import fp_vr_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int RES_W   = `FP_VR_RES_W,
    parameter int TAG_W   = `FP_VR_TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                dp_vld_o,
    input  logic [RES_W-1:0]    dp_res_i,
    input  logic [FFLAGS_W-1:0] dp_fflags_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_res,
    output logic [FFLAGS_W-1:0] out_fflags,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int CRED_W = cnt_w(DEPTH);
    localparam int ENT_W  = TAG_W + RES_W + FFLAGS_W;

    logic [CRED_W-1:0]  cred_q;
    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic               fire_in;
    logic               fire_out;
    logic               tail_vld;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CRED_W-1:0]  fifo_count;
    logic [ENT_W-1:0]   push_data;
    logic [ENT_W-1:0]   fifo_head;

    assign in_ready  = rst_n & (cred_q != '0);
    assign fire_in   = in_valid & in_ready;
    assign dp_vld_o  = fire_in;
    assign fire_out  = out_valid & out_ready;
    assign tail_vld  = vld_q[LATENCY-1];
    assign push_data = {tag_q[LATENCY-1], dp_res_i, dp_fflags_i};

    // One credit per buffer slot: an op holds its credit from acceptance until its response leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cred_q <= CRED_W'(DEPTH);
        end else begin
            case ({fire_in, fire_out})
                2'b10:   cred_q <= cred_q - CRED_W'(1);
                2'b01:   cred_q <= cred_q + CRED_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= fire_in;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

`ifdef FP_VR_RESP_BYPASS_EN
    logic byp_sel;

    // With nothing buffered the datapath tail is the oldest result, so it may go straight out.
    assign byp_sel   = fifo_empty & tail_vld;
    assign out_valid = ~fifo_empty | tail_vld;
    assign {out_tag, out_res, out_fflags} = byp_sel ? push_data : fifo_head;
    assign fifo_push = tail_vld & ~(byp_sel & out_ready);
`else
    assign out_valid = ~fifo_empty;
    assign {out_tag, out_res, out_fflags} = fifo_head;
    assign fifo_push = tail_vld;
`endif
    assign fifo_pop = out_ready & ~fifo_empty;

    fp_vr_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .CNT_W (CRED_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    a_cred_max: assert property (@(posedge clk) disable iff (!rst_n)
        cred_q <= CRED_W'(DEPTH));

    a_cred_conserved: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(fifo_count) + 32'($countones(vld_q)) + 32'(cred_q)) == 32'(DEPTH));

endmodule

// File: tb/tb_fp_vr_resp_shell.sv
// Randomised bench for fp_vr_resp_shell (LATENCY=2, DEPTH=4) against a queue-based
// transaction model; define FP_VR_RESP_BYPASS_EN to build and check the bypass variant.
module tb_fp_vr_resp_shell;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`ifdef FP_VR_RESP_BYPASS_EN
    localparam int AVAIL = LAT;
`else
    localparam int AVAIL = LAT + 1;
`endif

    typedef struct {
        logic [7:0]  tag;
        logic [15:0] res;
        logic [4:0]  ff;
        int          acc;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_tag;
    logic        dp_vld_o;
    logic [15:0] dp_res_i;
    logic [4:0]  dp_fflags_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [4:0]  out_fflags;
    logic [7:0]  out_tag;

    op_t         q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] obs_vec;
    logic [31:0] exp_vec;

    fp_vr_resp_shell #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .RES_W   (16),
        .TAG_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .dp_vld_o    (dp_vld_o),
        .dp_res_i    (dp_res_i),
        .dp_fflags_i (dp_fflags_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_fflags  (out_fflags),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    // One clock of stimulus. The model is a queue of accepted ops in order; an op's result is
    // on the datapath LAT cycles after acceptance and may leave AVAIL cycles after acceptance.
    task automatic cycle(input logic iv, input logic [7:0] tg, input logic ordy,
                         input logic rn, input logic [15:0] rs);
        op_t  o;
        logic exp_ir;
        logic exp_ov;
        logic exp_fire;
        rst_n       = rn;
        in_valid    = iv;
        in_tag      = tg;
        out_ready   = ordy;
        dp_res_i    = 16'($urandom);
        dp_fflags_i = 5'($urandom);
        foreach (q[i]) begin
            if (q[i].acc == cyc - LAT) begin
                dp_res_i    = q[i].res;
                dp_fflags_i = q[i].ff;
            end
        end
        exp_ir   = rn && (q.size() < DEPTH);
        exp_ov   = (q.size() > 0) && (q[0].acc + AVAIL <= cyc);
        exp_fire = iv && exp_ir;
        exp_vec  = {exp_ir, exp_fire, exp_ov,
                    exp_ov ? {q[0].tag, q[0].res, q[0].ff} : 29'd0};
        @(negedge clk);
        obs_vec  = {in_ready, dp_vld_o, out_valid,
                    out_valid ? {out_tag, out_res, out_fflags} : 29'd0};
        @(posedge clk);
        if (!rn) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) begin
                void'(q.pop_front());
            end
            if (exp_fire) begin
                o.tag = tg;
                o.res = rs;
                o.ff  = 5'($urandom);
                o.acc = cyc;
                q.push_back(o);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(i), 1'b1, (i >= 2), 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_op();
        for (int i = 0; i < 8; i++) begin
            cycle(i == 0, 8'h05, 1'b1, 1'b1, 16'h3C00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL single_op cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            cycle(i < 8, 8'(i), 1'b1, 1'b1, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_backpressure();
        // Stall the consumer long enough to exhaust credits and fill the buffer, then drain.
        for (int i = 0; i < 22; i++) begin
            cycle(i < 10, 8'(i), i >= 10, 1'b1, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_pop_with_push();
        logic iv_pat [16] = '{1,1,1,1,1,1,1, 0,1,0,0, 0,0,0,0,0};
        logic or_pat [16] = '{0,0,0,0,0,0,0, 1,0,0,1, 0,1,1,1,1};
        for (int i = 0; i < 16; i++) begin
            cycle(iv_pat[i], 8'(8'h40 + i), or_pat[i], 1'b1, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL pop_with_push cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL pop_with_push_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        // One op buffered and two in the datapath when reset hits; none may reappear.
        logic iv_pat [5] = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 18; i++) begin
            cycle((i < 5) ? iv_pat[i] : 1'b0, 8'(8'h80 + i), i >= 7,
                  !(i == 4 || i == 5), 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_mid_op cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

`ifdef FP_VR_RESP_BYPASS_EN
    task automatic test_bypass();
        for (int i = 0; i < 14; i++) begin
            cycle(i == 0 || i == 6, 8'(8'hB0 + i), (i < 6) || (i >= 10), 1'b1,
                  16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bypass cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                  ($urandom % 150) != 0, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1, 16'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_tag      = '0;
        out_ready   = 1'b0;
        dp_res_i    = '0;
        dp_fflags_i = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_pop_with_push();
        test_reset_mid_op();
`ifdef FP_VR_RESP_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
